// File: rtl/wash_sequencer.sv
// wash_sequencer: washing-machine phase sequencer with door pause and remaining-time countdown.
// Optional soap interlock enabled by defining WASH_SEQ_SOAP_CHECK_EN.
module wash_sequencer #(
    parameter int FILL_CYC   = 8,
    parameter int WASH_CYC   = 12,
    parameter int DRAIN_CYC  = 8,
    parameter int RINSE_CYC  = 9,
    parameter int RDRAIN_CYC = 15,
    parameter int SPIN_CYC   = 12,
    parameter int RW         = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [2:0]    program_sel,
    input  logic [1:0]    rinse_reps,
    input  logic          door_closed,
    input  logic          soap,
    output logic          valve_cold,
    output logic          valve_hot,
    output logic          valve_out,
    output logic [1:0]    motor,
    output logic [RW-1:0] remaining,
    output logic          soap_warning,
    output logic          paused,
    output logic          busy,
    output logic          program_done
);
    typedef enum logic [3:0] {IDLE, SOAP_WAIT, FILL, WASH, DRAIN, RINSE, RDRAIN, SPIN, PAUSE, DONE} state_t;
    state_t state, state_n, sav, sav_n, succ, adv, entry, fill_entry;
    logic [RW-1:0] tmr, tmr_n, rem_n, len, total, pair;
    logic [2:0] prog, prog_n;
    logic [1:0] rep, rep_n, reps_eff;
    logic [1:0] mot_n;
    logic last, vc_n, vh_n, vo_n, vc_r, vh_r;
    assign reps_eff = (rinse_reps == 2'd0) ? 2'd1 : rinse_reps;
    assign pair  = RW'(reps_eff) * RW'(RINSE_CYC + RDRAIN_CYC);
    assign total = (program_sel == 3'd4) ? RW'(SPIN_CYC) :
                   (program_sel == 3'd3) ? pair + RW'(SPIN_CYC) :
                   RW'(FILL_CYC + WASH_CYC + DRAIN_CYC + SPIN_CYC) + pair;
    assign len = (state == FILL)  ? RW'(FILL_CYC)  :
                 (state == WASH)  ? RW'(WASH_CYC)  :
                 (state == DRAIN) ? RW'(DRAIN_CYC) :
                 (state == RINSE) ? RW'(RINSE_CYC) :
                 (state == RDRAIN) ? RW'(RDRAIN_CYC) : RW'(SPIN_CYC);
    assign last = (tmr == len - 1'b1);
    assign succ = (state == FILL)   ? WASH  :
                  (state == WASH)   ? DRAIN :
                  (state == DRAIN)  ? RINSE :
                  (state == RINSE)  ? RDRAIN :
                  (state == RDRAIN) ? ((rep > 2'd1) ? RINSE : SPIN) : DONE;
    assign adv = last ? succ : state;
`ifdef WASH_SEQ_SOAP_CHECK_EN
    assign fill_entry = soap ? FILL : SOAP_WAIT;
`else
    assign fill_entry = FILL;
`endif
    assign entry = (program_sel == 3'd4) ? SPIN : (program_sel == 3'd3) ? RINSE : fill_entry;
    always_comb begin
        state_n = state;
        tmr_n   = tmr;
        rem_n   = remaining;
        sav_n   = sav;
        prog_n  = prog;
        rep_n   = rep;
        case (state)
            IDLE: if (start && door_closed && program_sel <= 3'd4) begin
                state_n = entry;
                prog_n  = program_sel;
                rep_n   = reps_eff;
                rem_n   = total;
                tmr_n   = '0;
            end
            SOAP_WAIT: if (soap) state_n = FILL;
            PAUSE: if (door_closed && start) state_n = sav;
            DONE: state_n = IDLE;
            default: begin
                // the timer and rinse count advance even when the door opens, so PAUSE saves the successor
                tmr_n   = last ? '0 : tmr + 1'b1;
                rep_n   = (last && state == RDRAIN && rep > 2'd1) ? rep - 2'd1 : rep;
                rem_n   = remaining - 1'b1;
                sav_n   = adv;
                state_n = door_closed ? adv : PAUSE;
            end
        endcase
    end
    assign vc_n  = (state_n == FILL && prog_n != 3'd1) || state_n == RINSE;
    assign vh_n  = state_n == FILL && prog_n != 3'd0;
    assign vo_n  = state_n == DRAIN || state_n == RDRAIN || state_n == SPIN;
    assign mot_n = (state_n == WASH || state_n == RINSE) ? 2'b01 : (state_n == SPIN) ? 2'b10 : 2'b00;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            sav          <= IDLE;
            tmr          <= '0;
            remaining    <= '0;
            prog         <= '0;
            rep          <= '0;
            vc_r         <= 1'b0;
            vh_r         <= 1'b0;
            valve_out    <= 1'b0;
            motor        <= 2'b00;
            paused       <= 1'b0;
            busy         <= 1'b0;
            program_done <= 1'b0;
        end else begin
            state        <= state_n;
            sav          <= sav_n;
            tmr          <= tmr_n;
            remaining    <= rem_n;
            prog         <= prog_n;
            rep          <= rep_n;
            vc_r         <= vc_n;
            vh_r         <= vh_n;
            valve_out    <= vo_n;
            motor        <= mot_n;
            paused       <= state_n == PAUSE;
            busy         <= state_n != IDLE;
            program_done <= state_n == DONE;
        end
    end
`ifdef WASH_SEQ_SOAP_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) soap_warning <= 1'b0;
        else     soap_warning <= state_n == SOAP_WAIT;
    end
    assign valve_cold = vc_r && (soap || state != FILL);
    assign valve_hot  = vh_r && (soap || state != FILL);
`else
    assign soap_warning = 1'b0;
    assign valve_cold   = vc_r;
    assign valve_hot    = vh_r;
`endif
endmodule

// File: tb/tb_wash_sequencer.sv
// tb_wash_sequencer: directed bench with a phase-list reference model checked every cycle.
module tb_wash_sequencer;
    logic clk = 1'b0;
    logic rst, start, door_closed, soap;
    logic [2:0] program_sel;
    logic [1:0] rinse_reps;
    logic valve_cold, valve_hot, valve_out, soap_warning, paused, busy, program_done;
    logic [1:0] motor;
    logic [11:0] remaining;
    logic [20:0] dv;
    int checks = 0;
    int failures = 0;

    wash_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .program_sel(program_sel), .rinse_reps(rinse_reps),
        .door_closed(door_closed), .soap(soap), .valve_cold(valve_cold), .valve_hot(valve_hot),
        .valve_out(valve_out), .motor(motor), .remaining(remaining), .soap_warning(soap_warning),
        .paused(paused), .busy(busy), .program_done(program_done)
    );

    always #5 clk = ~clk;
    assign dv = {valve_cold, valve_hot, valve_out, motor, soap_warning, paused, busy, program_done, remaining};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a program is a list of phases {outputs, length}; the run walks the list one cycle at a time.
    localparam int M_IDLE = 0, M_SW = 1, M_RUN = 2, M_PAUSE = 3, M_DONE = 4;
    int plen[$];
    logic [4:0] pout[$];
    int m_mode, m_sav, m_idx, m_left, m_rem, m_sel, m_reps, m_nxt;
    logic [4:0] e_o;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode = M_IDLE;
            m_rem  = 0;
        end else begin
            case (m_mode)
                M_IDLE: if (start && door_closed && program_sel <= 3'd4) begin
                    plen.delete();
                    pout.delete();
                    m_sel  = int'(program_sel);
                    m_reps = (rinse_reps == 2'd0) ? 1 : int'(rinse_reps);
                    if (m_sel <= 2) begin
                        plen.push_back(8);  pout.push_back({m_sel != 1, m_sel != 0, 1'b0, 2'b00});
                        plen.push_back(12); pout.push_back(5'b000_01);
                        plen.push_back(8);  pout.push_back(5'b001_00);
                    end
                    if (m_sel <= 3)
                        for (int r = 0; r < m_reps; r++) begin
                            plen.push_back(9);  pout.push_back(5'b100_01);
                            plen.push_back(15); pout.push_back(5'b001_00);
                        end
                    plen.push_back(12); pout.push_back(5'b001_10);
                    m_rem = 0;
                    foreach (plen[i]) m_rem += plen[i];
                    m_idx  = 0;
                    m_left = plen[0];
                    m_mode = M_RUN;
`ifdef WASH_SEQ_SOAP_CHECK_EN
                    if (m_sel <= 2 && !soap) m_mode = M_SW;
`endif
                end
                M_SW: if (soap) m_mode = M_RUN;
                M_RUN: begin
                    m_rem--;
                    m_left--;
                    m_nxt = M_RUN;
                    if (m_left == 0) begin
                        m_idx++;
                        if (m_idx == plen.size()) m_nxt = M_DONE;
                        else m_left = plen[m_idx];
                    end
                    if (!door_closed) begin
                        m_sav  = m_nxt;
                        m_mode = M_PAUSE;
                    end else m_mode = m_nxt;
                end
                M_PAUSE: if (door_closed && start) m_mode = m_sav;
                default: begin
                    m_mode = M_IDLE;
                    m_rem  = 0;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            e_o = (m_mode == M_RUN) ? pout[m_idx] : 5'b0;
`ifdef WASH_SEQ_SOAP_CHECK_EN
            if (m_mode == M_RUN && m_idx == 0 && m_sel <= 2 && !soap) e_o[4:3] = 2'b00;
`endif
            check("cycle", 32'(dv), 32'({e_o, m_mode == M_SW, m_mode == M_PAUSE, m_mode != M_IDLE,
                                         m_mode == M_DONE, 12'(m_rem)}));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!program_done && n < 400) begin
            cyc(1);
            n++;
        end
        check("done_seen", 32'(program_done), 1);
        cyc(1);
    endtask

    task automatic run_prog(input string nm, input int tot, input int lat, input int vo_exp);
        int n, vo;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        check({nm, "_first_rem"}, 32'(remaining), tot);
        n  = 1;
        vo = int'(valve_out);
        while (!program_done && n < 400) begin
            cyc(1);
            n++;
            vo += int'(valve_out);
        end
        check({nm, "_done_latency"}, n, lat);
        check({nm, "_valve_out_cycles"}, vo, vo_exp);
        cyc(1);
        check({nm, "_idle_after"}, 32'(busy), 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; door_closed = 1'b1; soap = 1'b1; program_sel = 3'd0; rinse_reps = 2'd1;
        cyc(3);
        check("reset_state", 32'(dv), 0);
        rst = 1'b0;
        cyc(1);
        program_sel = 3'd0; rinse_reps = 2'd1;
        run_prog("cold", 64, 65, 35);
        program_sel = 3'd3; rinse_reps = 2'd3;
        run_prog("rinse3", 84, 85, 57);
        program_sel = 3'd4;
        run_prog("spin", 12, 13, 12);
        // hot wash: door opens during WASH cycle 5 (active cycle 13) for 20 cycles
        program_sel = 3'd1; rinse_reps = 2'd1; start = 1'b1;
        cyc(1);
        start = 1'b0;
        check("hot_first_rem", 32'(remaining), 64);
        check("hot_fill_valves", 32'({valve_cold, valve_hot}), 32'b01);
        cyc(12);
        door_closed = 1'b0;
        cyc(1);
        check("hot_paused", 32'({paused, busy}), 32'b11);
        check("hot_pause_rem", 32'(remaining), 51);
        cyc(19);
        check("hot_pause_late", 32'(dv), 32'({5'b0, 4'b0110, 12'd51}));
        door_closed = 1'b1; start = 1'b1;
        cyc(1);
        start = 1'b0;
        check("hot_resume_motor", 32'(motor), 1);
        check("hot_resume_rem", 32'(remaining), 51);
        cyc(6);
        check("hot_wash_last", 32'(motor), 1);
        cyc(1);
        check("hot_drain", 32'({valve_out, motor}), 32'b100);
        wait_done();
        // reps=0 behaves as 1; door opens in the last RINSE cycle
        program_sel = 3'd3; rinse_reps = 2'd0; start = 1'b1;
        cyc(1);
        start = 1'b0;
        check("r0_first_rem", 32'(remaining), 36);
        cyc(8);
        door_closed = 1'b0;
        cyc(1);
        check("r0_pause", 32'({paused, remaining}), 32'({1'b1, 12'd27}));
        cyc(2);
        door_closed = 1'b1; start = 1'b1;
        cyc(1);
        start = 1'b0;
        check("r0_resume_rdrain", 32'({valve_out, motor, remaining}), 32'({1'b1, 2'b00, 12'd27}));
        wait_done();
        // invalid selection and door-open start are ignored
        program_sel = 3'd6; start = 1'b1;
        cyc(1);
        check("invalid_sel_busy", 32'(busy), 0);
        cyc(1);
        start = 1'b0;
        check("invalid_sel_busy2", 32'(busy), 0);
        program_sel = 3'd0; door_closed = 1'b0; start = 1'b1;
        cyc(2);
        check("door_open_start", 32'(busy), 0);
        door_closed = 1'b1; start = 1'b0;
        cyc(1);
        // asynchronous reset during SPIN, then immediate restart
        program_sel = 3'd4; start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(4);
        check("spin_motor", 32'(motor), 2);
        #1 rst = 1'b1;
        #1 check("async_reset", 32'(dv), 0);
        cyc(2);
        rst = 1'b0; start = 1'b1;
        cyc(1);
        start = 1'b0;
        check("restart_after_rst", 32'({busy, motor, remaining}), 32'({1'b1, 2'b10, 12'd12}));
        wait_done();
`ifdef WASH_SEQ_SOAP_CHECK_EN
        program_sel = 3'd2; rinse_reps = 2'd1; soap = 1'b0; start = 1'b1;
        cyc(1);
        start = 1'b0;
        check("soap_wait", 32'({soap_warning, valve_cold, valve_hot, remaining}), 32'({3'b100, 12'd64}));
        cyc(9);
        check("soap_wait_held", 32'({soap_warning, valve_cold, valve_hot, remaining}), 32'({3'b100, 12'd64}));
        soap = 1'b1;
        cyc(1);
        check("soap_fill", 32'({soap_warning, valve_cold, valve_hot, remaining}), 32'({3'b011, 12'd64}));
        wait_done();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
